// File: rtl/irq_service_responder.sv
// Peripheral/CPU-side partner of the 4-line interrupt controller: latches event edges into
// pending requests, hands the granted vector to the CPU and acknowledges the peripheral after EOI.
module irq_service_responder #(
    parameter int NUM_IRQ = 4,
    parameter int VEC_W   = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] event_in,
    output logic [NUM_IRQ-1:0] req_out,
    input  logic [NUM_IRQ-1:0] grant_in,
    output logic               vec_valid,
    output logic [VEC_W-1:0]   vec_id,
    input  logic               vec_ready,
    input  logic               eoi,
    output logic [NUM_IRQ-1:0] ack_pulse,
    output logic               busy,
    output logic [NUM_IRQ-1:0] overflow,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_SERVICE = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    localparam logic [NUM_IRQ-1:0] ZERO_V     = {NUM_IRQ{1'b0}};
    localparam logic [NUM_IRQ-1:0] ONE_V      = {{(NUM_IRQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   ZERO_CNT   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   ONE_CNT    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT - 1);

    function automatic logic is_one_hot(input logic [NUM_IRQ-1:0] v);
        return (v != ZERO_V) && ((v & (v - ONE_V)) == ZERO_V);
    endfunction

    function automatic logic [VEC_W-1:0] encode_id(input logic [NUM_IRQ-1:0] v);
        logic [VEC_W-1:0] id;
        id = {VEC_W{1'b0}};
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) begin
                id = VEC_W'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    function automatic logic [NUM_IRQ-1:0] decode_id(input logic [VEC_W-1:0] id);
        logic [NUM_IRQ-1:0] m;
        m = ZERO_V;
        m[id] = 1'b1;
        return m;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [NUM_IRQ-1:0] prev_r, rise_s;
    logic [NUM_IRQ-1:0] req_r, req_nxt_s, clr_mask_s;
    logic [NUM_IRQ-1:0] ovf_r, ovf_set_s;
    logic [NUM_IRQ-1:0] ack_r, ack_nxt_s;
    logic               vec_valid_r, vec_valid_nxt_s;
    logic [VEC_W-1:0]   vec_id_r, vec_id_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               tmo_r, tmo_nxt_s;
    logic               busy_r;

    assign rise_s = event_in & ~prev_r;

    // Next-state and next-output logic; vec_id_r doubles as the latched service index.
    always_comb begin
        state_nxt_s     = state_r;
        vec_valid_nxt_s = vec_valid_r;
        vec_id_nxt_s    = vec_id_r;
        cnt_nxt_s       = cnt_r;
        tmo_nxt_s       = 1'b0;
        ack_nxt_s       = ZERO_V;
        clr_mask_s      = ZERO_V;
        ovf_set_s       = rise_s & req_r;
        case (state_r)
            ST_IDLE: begin
                if (is_one_hot(grant_in) && ((grant_in & req_r) != ZERO_V)) begin
                    state_nxt_s     = ST_PRESENT;
                    vec_valid_nxt_s = 1'b1;
                    vec_id_nxt_s    = encode_id(grant_in);
                    cnt_nxt_s       = ZERO_CNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (vec_ready) begin
                    state_nxt_s     = ST_SERVICE;
                    vec_valid_nxt_s = 1'b0;
                    cnt_nxt_s       = ZERO_CNT;
                end else if (cnt_r == TMO_LAST) begin
                    // Request stays pending so the controller re-arbitrates it.
                    state_nxt_s     = ST_IDLE;
                    vec_valid_nxt_s = 1'b0;
                    tmo_nxt_s       = 1'b1;
                    cnt_nxt_s       = ZERO_CNT;
                end else begin
                    cnt_nxt_s = cnt_r + ONE_CNT;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            ST_CLEAR: begin
                // A fresh rise on the serviced channel re-arms it without flagging overflow.
                clr_mask_s  = decode_id(vec_id_r);
                ack_nxt_s   = clr_mask_s;
                ovf_set_s   = rise_s & req_r & ~clr_mask_s;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                vec_valid_nxt_s = 1'b0;
                cnt_nxt_s       = ZERO_CNT;
            end
        endcase
        req_nxt_s = (req_r & ~clr_mask_s) | rise_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prev_r      <= ZERO_V;
            req_r       <= ZERO_V;
            ovf_r       <= ZERO_V;
            ack_r       <= ZERO_V;
            vec_valid_r <= 1'b0;
            vec_id_r    <= {VEC_W{1'b0}};
            cnt_r       <= ZERO_CNT;
            tmo_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            prev_r      <= event_in;
            req_r       <= req_nxt_s;
            ovf_r       <= ovf_r | ovf_set_s;
            ack_r       <= ack_nxt_s;
            vec_valid_r <= vec_valid_nxt_s;
            vec_id_r    <= vec_id_nxt_s;
            cnt_r       <= cnt_nxt_s;
            tmo_r       <= tmo_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign req_out     = req_r;
    assign vec_valid   = vec_valid_r;
    assign vec_id      = vec_id_r;
    assign ack_pulse   = ack_r;
    assign busy        = busy_r;
    assign overflow    = ovf_r;
    assign timeout_err = tmo_r;

endmodule

// File: tb/tb_irq_service_responder.sv
// Directed bench for irq_service_responder: hand-computed expectations checked with immediate assertions.
module tb_irq_service_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] event_in;
    logic [3:0] req_out;
    logic [3:0] grant_in;
    logic       vec_valid;
    logic [1:0] vec_id;
    logic       vec_ready;
    logic       eoi;
    logic [3:0] ack_pulse;
    logic       busy;
    logic [3:0] overflow;
    logic       timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    irq_service_responder dut (
        .clk        (clk),
        .rst        (rst),
        .event_in   (event_in),
        .req_out    (req_out),
        .grant_in   (grant_in),
        .vec_valid  (vec_valid),
        .vec_id     (vec_id),
        .vec_ready  (vec_ready),
        .eoi        (eoi),
        .ack_pulse  (ack_pulse),
        .busy       (busy),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [3:0] exp_req, input logic [3:0] exp_ovf);
        check({tag, ".req"},  {28'd0, req_out},   {28'd0, exp_req});
        check({tag, ".vv"},   {31'd0, vec_valid}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy},      32'd0);
        check({tag, ".ack"},  {28'd0, ack_pulse}, 32'd0);
        check({tag, ".ovf"},  {28'd0, overflow},  {28'd0, exp_ovf});
    endtask

    initial begin
        rst = 1'b1; event_in = 4'b0000; grant_in = 4'b0000; vec_ready = 1'b0; eoi = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset", 4'b0000, 4'b0000);
        check("reset.id",  {30'd0, vec_id}, 32'd0);
        check("reset.tmo", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // Basic service of channel 2
        event_in = 4'b0100;
        tick();
        check("t1.req", {28'd0, req_out}, 32'h4);
        check("t1.vv0", {31'd0, vec_valid}, 32'd0);
        event_in = 4'b0000; grant_in = 4'b0100;
        tick();
        check("t1.vv",   {31'd0, vec_valid}, 32'd1);
        check("t1.id",   {30'd0, vec_id}, 32'd2);
        check("t1.busy", {31'd0, busy}, 32'd1);
        grant_in = 4'b0000; vec_ready = 1'b1;
        tick();
        check("t1.vv_hs", {31'd0, vec_valid}, 32'd0);
        check("t1.busy2", {31'd0, busy}, 32'd1);
        check("t1.id_hold", {30'd0, vec_id}, 32'd2);
        vec_ready = 1'b0; eoi = 1'b1;
        tick();
        check("t1.ack_early", {28'd0, ack_pulse}, 32'd0);
        check("t1.req_clr_early", {28'd0, req_out}, 32'h4);
        eoi = 1'b0;
        tick();
        check("t1.ack",  {28'd0, ack_pulse}, 32'h4);
        check("t1.req0", {28'd0, req_out}, 32'd0);
        check("t1.busy0", {31'd0, busy}, 32'd0);
        tick();
        check("t1.ack_once", {28'd0, ack_pulse}, 32'd0);

        // Ignored grants: multi-hot, zero, non-pending
        event_in = 4'b0011;
        tick();
        check("t2.req", {28'd0, req_out}, 32'h3);
        event_in = 4'b0000; grant_in = 4'b0011;
        tick();
        tick();
        check_idle_outputs("t2.multi", 4'b0011, 4'b0000);
        grant_in = 4'b1000;
        tick();
        tick();
        check_idle_outputs("t2.nonpend", 4'b0011, 4'b0000);
        grant_in = 4'b0000;
        eoi = 1'b1;
        tick();
        check_idle_outputs("t6.eoi_idle", 4'b0011, 4'b0000);
        eoi = 1'b0;

        // Timeout on channel 0; eoi during PRESENT is ignored
        grant_in = 4'b0001;
        tick();
        check("t3.vv1", {31'd0, vec_valid}, 32'd1);
        check("t3.id",  {30'd0, vec_id}, 32'd0);
        grant_in = 4'b0000;
        for (int i = 2; i <= 16; i++) begin
            eoi = (i == 3);
            tick();
            check($sformatf("t3.vv%0d", i), {31'd0, vec_valid}, 32'd1);
            check($sformatf("t3.tmo%0d", i), {30'd0, timeout_err, ack_pulse[0]}, 32'd0);
        end
        eoi = 1'b0;
        tick();
        check("t3.tmo",  {31'd0, timeout_err}, 32'd1);
        check("t3.vv_drop", {31'd0, vec_valid}, 32'd0);
        check("t3.busy", {31'd0, busy}, 32'd0);
        check("t3.req",  {28'd0, req_out}, 32'h3);
        tick();
        check("t3.tmo_once", {31'd0, timeout_err}, 32'd0);

        // Overflow on channel 1 (already pending from the ignored-grant step)
        event_in = 4'b0010;
        tick();
        check("t4.ovf1", {28'd0, overflow}, 32'h2);
        event_in = 4'b0000;
        tick();
        event_in = 4'b0010;
        tick();
        check("t4.ovf2", {28'd0, overflow}, 32'h2);
        event_in = 4'b0000; grant_in = 4'b0010;
        tick();
        check("t4.id", {30'd0, vec_id}, 32'd1);
        grant_in = 4'b0000; vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0; eoi = 1'b1;
        tick();
        eoi = 1'b0; event_in = 4'b0010;
        tick();
        check("t4.ack",  {28'd0, ack_pulse}, 32'h2);
        check("t4.req",  {28'd0, req_out}, 32'h3);
        check("t4.ovf3", {28'd0, overflow}, 32'h2);
        check("t4.busy", {31'd0, busy}, 32'd0);
        event_in = 4'b0000;
        tick();
        check_idle_outputs("t4.after", 4'b0011, 4'b0010);

        // Build req_out=1001 and reset in SERVICE
        event_in = 4'b1000;
        tick();
        event_in = 4'b0000; grant_in = 4'b0010;
        tick();
        grant_in = 4'b0000; vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0; eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        check("t5.ack1", {28'd0, ack_pulse}, 32'h2);
        check("t5.req",  {28'd0, req_out}, 32'h9);
        grant_in = 4'b1000;
        tick();
        check("t5.id3", {30'd0, vec_id}, 32'd3);
        grant_in = 4'b0000; vec_ready = 1'b1;
        tick();
        check("t5.busy", {31'd0, busy}, 32'd1);
        vec_ready = 1'b0; rst = 1'b1; event_in = 4'b0001; eoi = 1'b1;
        tick();
        check_idle_outputs("t5.rst", 4'b0000, 4'b0000);
        check("t5.rst_id",  {30'd0, vec_id}, 32'd0);
        tick();
        check("t5.rst_ack", {28'd0, ack_pulse}, 32'd0);
        rst = 1'b0; eoi = 1'b0;
        check("t5.req_c1", {28'd0, req_out}, 32'd0);
        tick();
        check("t5.req_c2", {28'd0, req_out}, 32'h1);
        check("t5.ack_c2", {28'd0, ack_pulse}, 32'd0);
        check("t5.busy_c2", {31'd0, busy}, 32'd0);
        event_in = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
